multibyte_add_seq: RTL
======================

// Module: multibyte_add_seq
// PURPOSE
//   Sequencer that drives one external 8-bit ripple-carry adder (bitadder8) over
//   NBYTES cycles to add or subtract wide operands, byte-serial, LSB byte first.
//   Feeds the adder's a/b/cin each cycle and consumes its s/cout, chaining the
//   carry through a register. valid/ready handshakes on both the operand and result sides.
// PARAMETERS
//   NBYTES  4  operand width in bytes (>=2); W = 8*NBYTES
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   rst_n      in   1   asynchronous, active-low reset
//   in_valid   in   1   operand request valid
//   in_ready   out  1   sequencer can accept an operand request
//   op_a       in   W   operand A
//   op_b       in   W   operand B
//   op_cin     in   1   carry-in for add; ignored when op_sub=1
//   op_sub     in   1   1: A-B (two's complement), 0: A+B+cin
//   add_a      out  8   to adder a
//   add_b      out  8   to adder b
//   add_cin    out  1   to adder carry-in
//   add_s      in   8   from adder sum
//   add_cout   in   1   from adder carry-out
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   sum        out  W   result
//   cout       out  1   final carry-out (for sub: 1 = no borrow)
//   ovf        out  1   signed overflow
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//     ovf=0, byte index=0, carry reg=0. Reset mid-operation drops the job silently.
//   FSM: IDLE -> RUN on in_valid&in_ready; RUN -> DONE after byte NBYTES-1 stored;
//     DONE -> IDLE on out_valid&out_ready.
//   IDLE: in_ready=1; on accept, latch op_a, op_b^{W{op_sub}}, first carry =
//     op_sub ? 1 : op_cin; clear sum; idx=0.
//   RUN: in_ready=0. add_a/add_b = byte idx of latched A/B, add_cin = carry reg
//     (combinational from registers). Each edge: sum byte idx <= add_s,
//     carry reg <= add_cout, idx++. Adder path must close in one cycle.
//   Last byte edge additionally: cout <= add_cout; ovf <= (A[W-1]==Beff[W-1]) &&
//     (add_s[7]!=A[W-1]).
//   Latency: out_valid rises exactly NBYTES clock edges after the accepting edge.
//   DONE: out_valid=1; sum/cout/ovf stable until handshake; in_ready=0.
//   No overlap: new request accepted only in IDLE (one idle cycle between jobs).
//   In IDLE/DONE: add_a=add_b=0, add_cin=0.
//   Operand ports ignored except at the accepting edge.
//   out_ready held 0: stay in DONE indefinitely, outputs unchanged.
// TESTING
//   NBYTES=4, add 0x000000FF+0x00000001, cin=0 -> sum=0x00000100, cout=0,
//     ovf=0, out_valid 4 edges after accept.
//   Add 0xFFFFFFFF+0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0 (full carry chain).
//   Add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, ovf=1, cout=0.
//   Sub 0x00000005-0x00000007 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
//   Hold out_ready=0 for 10 cycles in DONE -> sum/out_valid stable, in_ready=0,
//     in_valid pulses ignored; release -> IDLE next edge.
//   Assert rst_n=0 asynchronously during RUN idx=2 -> out_valid=0, in_ready=1
//     immediately; next job gives correct result.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq
//   Byte-serial wide add/subtract sequencer. It drives one external 8-bit
//   ripple-carry adder over NBYTES cycles, LSB byte first, and chains the
//   adder's carry-out back into its carry-in through a register. Subtraction
//   is A + ~B + 1 (two's complement). Operands are taken with a valid/ready
//   handshake, and the result is offered with another one.
//
// Parameters
//   NBYTES     operand width in bytes (>= 2); W = 8*NBYTES
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset; drops any job in flight
//   in_valid   operand request valid
//   in_ready   sequencer idle and able to accept a request
//   op_a/op_b  W-bit operands, sampled only at the accepting edge
//   op_cin     carry-in for add (ignored when op_sub=1)
//   op_sub     1: A-B, 0: A+B+cin
//   add_a/add_b/add_cin   to the external 8-bit adder (zero outside RUN)
//   add_s/add_cout        from the external adder (must settle in one cycle)
//   out_valid  result valid; sum/cout/ovf held until out_ready
//   out_ready  consumer accepts the result
//   sum        W-bit result
//   cout       final carry-out (for subtract: 1 = no borrow)
//   ovf        signed overflow

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  op_cin,
    input  logic                  op_sub,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [NBYTES-1:0][7:0]  a_q;      // latched A
    logic [NBYTES-1:0][7:0]  b_q;      // latched B, already inverted for subtract
    logic [NBYTES-1:0][7:0]  sum_q;
    logic                    carry_q;  // carry chained between byte slices
    logic [IW-1:0]           idx_q;    // byte currently presented to the adder
    logic                    last_byte;
    logic                    accept;

    assign last_byte = (idx_q == IW'(NBYTES - 1));
    assign accept    = in_valid && in_ready;
    assign sum       = sum_q;

    // Adder inputs come straight from registers so the only combinational
    // path per cycle is register -> external adder -> register.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= op_a;
                        b_q      <= op_b ^ {W{op_sub}};
                        carry_q  <= op_sub ? 1'b1 : op_cin;
                        sum_q    <= '0;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    sum_q[idx_q] <= add_s;
                    carry_q      <= add_cout;
                    if (last_byte) begin
                        cout      <= add_cout;
                        // Same-sign operands producing an opposite-sign result.
                        ovf       <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                                     (add_s[7] != a_q[NBYTES-1][7]);
                        idx_q     <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    idx_q     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The two handshake sides are never open at the same time.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(in_ready && out_valid))
                else $error("in_ready and out_valid both high");
        end
    end

endmodule
